jtag_debug_action_queue: RTL
============================

JTAG_DEBUG_ACTION_QUEUE -- requirements
Module: jtag_debug_action_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 38, JTAG shift-register snapshot width.
REQ-002 SHALL have parameter IR_W, default 2, instruction width; channel count NCH = 2**IR_W.
REQ-003 SHALL have parameter DEPTH, default 4, command queue depth; must be a power of two and at least 2.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchroniser length; must be at least 2.
REQ-005 SHALL have parameter ACT_BIT, default 34, index of the action/no-action flag bit in sr.
REQ-006 SHALL have the ports below; one clock, reset synchronous and active-low:
  clk  in  1  system clock
  reset_n  in  1  synchronous active-low reset
  udr_tgl  in  1  TCK-domain toggle; flips once per update-DR
  sr  in  DATA_W  TCK-domain shift snapshot; stable for at least SYNC_STAGES+2 clk after each udr_tgl flip
  ir_in  in  IR_W  TCK-domain instruction; same stability as sr
  rti  in  1  TCK-domain run-test-idle level
  cmd_ready  in  1  consumer accepts head entry
  ovf_clr  in  1  clears the overflow flag and the drop counter
  cmd_valid  out  1  queue non-empty
  cmd_ir  out  IR_W  head-entry instruction
  cmd_act  out  1  head-entry action flag
  jdo  out  DATA_W  data of the most recently popped entry
  take_action  out  NCH  one-hot pulse for an action pop
  take_no_action  out  NCH  one-hot pulse for a no-action pop
  st_ready_test_idle  out  1  synchronised rti
  overflow  out  1  sticky drop flag
  drop_cnt  out  8  count of dropped events

Function
REQ-007 SHALL pass udr_tgl and rti through separate SYNC_STAGES-flop synchronisers; st_ready_test_idle SHALL be the rti synchroniser output.
REQ-008 SHALL detect an update event in any cycle where the synchronised udr_tgl differs from its registered previous value (either polarity).
REQ-009 In the event cycle, SHALL sample {ir_in, sr[ACT_BIT], sr} and write them to the queue at the next clock edge.
REQ-010 SHALL implement the queue as a DEPTH-entry circular buffer with wrapping read/write pointers and an occupancy count of width log2(DEPTH)+1.
REQ-011 SHALL hold cmd_valid high whenever occupancy is nonzero; cmd_ir and cmd_act SHALL show the head entry with no added latency.
REQ-012 SHALL pop the head entry on a clock edge where cmd_valid and cmd_ready are both high; cmd_ready with an empty queue SHALL have no effect.
REQ-013 On a pop, SHALL load jdo with the popped data; jdo SHALL hold that value until the next pop.
REQ-014 In the cycle after a pop, SHALL assert exactly one bit, index = popped ir: take_action if act=1, otherwise take_no_action; all other bits SHALL be 0.
REQ-015 Latency from a udr_tgl flip to cmd_valid rising, with the queue empty: SYNC_STAGES+2 clk.
REQ-016 Push and pop in the same cycle SHALL both succeed at any occupancy, including full; occupancy SHALL be unchanged.
REQ-017 A push at full with no pop SHALL drop the event: queue unchanged, overflow set to 1, drop_cnt incremented, saturating at 255.
REQ-018 ovf_clr SHALL clear overflow and drop_cnt; if a drop occurs in the same cycle, set SHALL win: overflow=1, drop_cnt=1.
REQ-019 Events arriving faster than one per clk are out of scope; at most one push per cycle.

Reset
REQ-020 While reset_n=0 at a clock edge, the block SHALL clear: synchronisers, edge reference, pointers, occupancy, jdo, take_action, take_no_action, overflow, drop_cnt.
REQ-021 After reset deasserts, SHALL suppress event detection for SYNC_STAGES+1 cycles while the edge reference tracks the synchronised udr_tgl; no spurious push if udr_tgl=1 at reset.
REQ-022 Reset mid-operation SHALL discard queued entries and any in-flight pulse.

Configuration
REQ-023 Macro JTAG_DBG_ACT_DROP_CNT_EN: when defined, drop_cnt SHALL behave per REQ-017/018; when undefined, drop_cnt SHALL be constant 0, no counter logic, and overflow SHALL be unchanged.

Verification
REQ-024 Empty queue, IR=2, sr[34]=1, flip udr_tgl -> cmd_valid at +4 clk (SYNC_STAGES=2); on pop, jdo=sr and take_action=4'b0100 for 1 clk.
REQ-025 Five events, IR 0..3,0 with cmd_ready=0 -> four queued, overflow=1, drop_cnt=1; drain in order 0,1,2,3.
REQ-026 Full queue, flip udr_tgl with cmd_ready=1 in the event-write cycle -> pop and push both succeed, occupancy stays 4, overflow stays 0.
REQ-027 udr_tgl held 1 through reset release -> no push; a subsequent flip to 0 -> exactly one push.
REQ-028 256 drops then ovf_clr together with one more drop -> drop_cnt 255 before, then 1; overflow=1. Macro undefined -> drop_cnt stays 0.

Source files
------------

// File: rtl/jtag_debug_action_queue.sv
// JTAG update-DR event queue. TCK-domain snapshots are synchronised into clk and queued as commands.
// Optional macro JTAG_DBG_ACT_DROP_CNT_EN enables the saturating dropped-event counter on drop_cnt.
module jtag_debug_action_queue #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = 34
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 udr_tgl,
  input  logic [DATA_W-1:0]    sr,
  input  logic [IR_W-1:0]      ir_in,
  input  logic                 rti,
  input  logic                 cmd_ready,
  input  logic                 ovf_clr,
  output logic                 cmd_valid,
  output logic [IR_W-1:0]      cmd_ir,
  output logic                 cmd_act,
  output logic [DATA_W-1:0]    jdo,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action,
  output logic                 st_ready_test_idle,
  output logic                 overflow,
  output logic [7:0]           drop_cnt
);

  localparam int NCH   = 2**IR_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IR_W + 1 + DATA_W;
  localparam int SUP_W = $clog2(SYNC_STAGES + 2);
  localparam logic [SUP_W-1:0] SUP_DONE = SUP_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [SYNC_STAGES-1:0] udr_sync_q, rti_sync_q;
  logic                   udr_ref_q;
  logic [SUP_W-1:0]       sup_cnt_q;
  logic                   evt_d, evt_q;
  logic                   udr_s;

  // Stage: clock-domain crossing and edge detection
  assign udr_s = udr_sync_q[SYNC_STAGES-1];
  assign st_ready_test_idle = rti_sync_q[SYNC_STAGES-1];
  assign evt_d = (sup_cnt_q == SUP_DONE) && (udr_s != udr_ref_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      udr_sync_q <= '0;
      rti_sync_q <= '0;
      udr_ref_q  <= 1'b0;
      sup_cnt_q  <= '0;
      evt_q      <= 1'b0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], udr_tgl};
      rti_sync_q <= {rti_sync_q[SYNC_STAGES-2:0], rti};
      udr_ref_q  <= udr_s;
      if (sup_cnt_q != SUP_DONE) sup_cnt_q <= sup_cnt_q + 1'b1;
      evt_q      <= evt_d;
    end
  end

  // Stage: circular command buffer
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ENT_W-1:0] head;
  logic             full, push, pop, wr_en, drop;

  assign head      = mem_q[rd_ptr_q];
  assign full      = (cnt_q == FULL_CNT);
  assign push      = evt_q;
  assign pop       = (cnt_q != '0) && cmd_ready;
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign cmd_valid = (cnt_q != '0);
  assign cmd_ir    = head[ENT_W-1 -: IR_W];
  assign cmd_act   = head[DATA_W];

  always_comb begin
    cnt_d = cnt_q;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ir_in, sr[ACT_BIT], sr};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Stage: pop outputs, one-hot pulses one cycle after the pop edge
  logic [DATA_W-1:0] jdo_q;
  logic [NCH-1:0]    take_act_d, take_act_q, take_nact_d, take_nact_q;

  always_comb begin
    take_act_d  = '0;
    take_nact_d = '0;
    if (pop) begin
      if (cmd_act) take_act_d[cmd_ir]  = 1'b1;
      else         take_nact_d[cmd_ir] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      jdo_q       <= '0;
      take_act_q  <= '0;
      take_nact_q <= '0;
    end else begin
      if (pop) jdo_q <= head[DATA_W-1:0];
      take_act_q  <= take_act_d;
      take_nact_q <= take_nact_d;
    end
  end

  assign jdo            = jdo_q;
  assign take_action    = take_act_q;
  assign take_no_action = take_nact_q;

  // Stage: overflow tracking; a drop in the clear cycle takes priority
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!reset_n)     ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  assign overflow = ovf_q;

`ifdef JTAG_DBG_ACT_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      if (ovf_clr)                 drop_cnt_q <= 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      drop_cnt_q <= '0;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule
